efx_fifo_5k: RTL and testbench

EFX_FIFO_5K -- requirements
Module: efx_fifo_5k

---
 rtl/efx_pkg.sv | 23 ++
 rtl/EFX_RAM_5K.sv | 77 +++++++
 rtl/efx_fifo_ctrl.sv | 108 ++++++++++
 rtl/efx_fifo_5k.sv | 87 ++++++++
 tb/tb_efx_fifo_5k.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/efx_pkg.sv
// Shared Efinix primitive helpers.
// RAM_5K width-to-address-width map and legal-width check, used by the
// EFX_RAM_5K model and every block built on top of it.
package efx_pkg;

  // Address width of a RAM_5K port for a given data width; 0 marks an
  // unsupported width.
  function automatic int unsigned efx_ram5k_addr_width(input int unsigned width);
    case (width)
      20, 16:  return 8;
      10, 8:   return 9;
      5, 4:    return 10;
      2:       return 11;
      1:       return 12;
      default: return 0;
    endcase
  endfunction

  function automatic bit efx_ram5k_width_legal(input int unsigned width);
    return efx_ram5k_addr_width(width) != 0;
  endfunction

endpackage

// File: rtl/EFX_RAM_5K.sv
// Behavioural model of the Efinix RAM_5K simple dual-port block RAM.
// Ports:
//   WCLK/WCLKE/WE/WADDR/WDATA - write port
//   RCLK/RE/RADDR/RDATA       - read port; RDATA holds when RE is inactive
// Only rising-edge clocks and READ_FIRST collision behaviour are modelled.
module EFX_RAM_5K
  import efx_pkg::*;
#(
  parameter int unsigned READ_WIDTH     = 20,
  parameter int unsigned WRITE_WIDTH    = 20,
  parameter bit          OUTPUT_REG     = 1'b0,
  parameter bit          RCLK_POLARITY  = 1'b1,
  parameter bit          RE_POLARITY    = 1'b1,
  parameter bit          WCLK_POLARITY  = 1'b1,
  parameter bit          WCLKE_POLARITY = 1'b1,
  parameter bit          WE_POLARITY    = 1'b1,
  parameter              WRITE_MODE     = "READ_FIRST",
  localparam int unsigned ADDR_WIDTH    = efx_ram5k_addr_width(WRITE_WIDTH),
  localparam int unsigned DEPTH         = 1 << ADDR_WIDTH
) (
  input  logic [WRITE_WIDTH-1:0] WDATA,
  input  logic [ADDR_WIDTH-1:0]  WADDR,
  input  logic                   WE,
  input  logic                   WCLK,
  input  logic                   WCLKE,
  output logic [READ_WIDTH-1:0]  RDATA,
  input  logic [ADDR_WIDTH-1:0]  RADDR,
  input  logic                   RE,
  input  logic                   RCLK
);

  // Elaboration-time rejection of configurations the model does not cover.
  if (READ_WIDTH != WRITE_WIDTH || !efx_ram5k_width_legal(WRITE_WIDTH)) begin : g_bad_width
    $error("EFX_RAM_5K: unsupported READ_WIDTH/WRITE_WIDTH");
  end
  if (!RCLK_POLARITY || !WCLK_POLARITY) begin : g_bad_clk
    $error("EFX_RAM_5K: only rising-edge clocks are modelled");
  end
  if (WRITE_MODE != "READ_FIRST") begin : g_bad_mode
    $error("EFX_RAM_5K: only READ_FIRST is modelled");
  end

  logic                   w_we;
  logic                   w_wclke;
  logic                   w_re;
  logic [WRITE_WIDTH-1:0] r_mem [DEPTH];
  logic [READ_WIDTH-1:0]  r_rdata;

  assign w_we    = WE    ~^ WE_POLARITY;
  assign w_wclke = WCLKE ~^ WCLKE_POLARITY;
  assign w_re    = RE    ~^ RE_POLARITY;

  // Write port; contents are never cleared.
  always_ff @(posedge WCLK) begin
    if (w_we && w_wclke) begin
      r_mem[WADDR] <= WDATA;
    end
  end

  // Read port; a same-address write lands after the read (READ_FIRST).
  always_ff @(posedge RCLK) begin
    if (w_re) begin
      r_rdata <= r_mem[RADDR];
    end
  end

  if (OUTPUT_REG) begin : g_oreg
    logic [READ_WIDTH-1:0] r_rdata_q;
    always_ff @(posedge RCLK) begin
      r_rdata_q <= r_rdata;
    end
    assign RDATA = r_rdata_q;
  end else begin : g_noreg
    assign RDATA = r_rdata;
  end

endmodule

// File: rtl/efx_fifo_ctrl.sv
// Pointer, occupancy and flag control for a single-clock RAM-backed FIFO.
// Ports:
//   i_clk, i_sr            - clock, synchronous active-high reset
//   i_we, i_re             - write/read requests
//   o_waddr, o_raddr       - RAM addresses (current pointers)
//   o_ram_we_c, o_ram_re_c - RAM enables, only on accepted requests
//   o_count + flags        - registered occupancy and status
//   o_rvalid               - qualifies RAM read data one cycle after a read
//   o_overflow/underflow   - one-cycle pulses on rejected requests
module efx_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int unsigned AEMPTY_THRESH = 4,
  localparam int unsigned DEPTH        = 1 << ADDR_WIDTH,
  localparam int unsigned CNT_W        = ADDR_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_sr,
  input  logic                  i_we,
  input  logic                  i_re,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  output logic                  o_ram_we_c,
  output logic                  o_ram_re_c,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_afull,
  output logic                  o_empty,
  output logic                  o_aempty,
  output logic                  o_rvalid,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_rvalid;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [CNT_W-1:0]      w_count_nxt;

  // Acceptance uses the registered flags; reset suppresses both sides.
  assign w_wr_acc = i_we & ~r_full  & ~i_sr;
  assign w_rd_acc = i_re & ~r_empty & ~i_sr;

  // Next occupancy.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count and flags; flags come from the next count so they
  // line up with o_count in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_sr) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_afull     <= (AFULL_THRESH == 0);
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + ADDR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_rptr <= r_rptr + ADDR_WIDTH'(1);
      end
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CNT_W'(DEPTH));
      r_afull     <= (32'(w_count_nxt) >= AFULL_THRESH);
      r_empty     <= (w_count_nxt == '0);
      r_aempty    <= (32'(w_count_nxt) <= AEMPTY_THRESH);
      r_rvalid    <= w_rd_acc;
      r_overflow  <= i_we & r_full;
      r_underflow <= i_re & r_empty;
    end
  end

  assign o_waddr     = r_wptr;
  assign o_raddr     = r_rptr;
  assign o_ram_we_c  = w_wr_acc;
  assign o_ram_re_c  = w_rd_acc;
  assign o_count     = r_count;
  assign o_full      = r_full;
  assign o_afull     = r_afull;
  assign o_empty     = r_empty;
  assign o_aempty    = r_aempty;
  assign o_rvalid    = r_rvalid;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/efx_fifo_5k.sv
// Single-clock FIFO on one RAM_5K block.
// Ports:
//   i_clk, i_sr                  - clock, synchronous active-high reset
//   i_we, i_wdata, o_full, o_afull
//   i_re, o_rdata, o_rvalid, o_empty, o_aempty
//   o_count                      - stored entries, 0..DEPTH
//   o_overflow, o_underflow      - pulses on rejected write / read
// RDATA comes straight from the RAM read register, so it holds between reads.
module efx_fifo_5k
  import efx_pkg::*;
#(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned AFULL_THRESH  = (1 << efx_ram5k_addr_width(WIDTH)) - 4,
  parameter int unsigned AEMPTY_THRESH = 4,
  localparam int unsigned ADDR_WIDTH   = efx_ram5k_addr_width(WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_sr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_we,
  output logic                  o_full,
  output logic                  o_afull,
  input  logic                  i_re,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_rvalid,
  output logic                  o_empty,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  if (!efx_ram5k_width_legal(WIDTH)) begin : g_bad_width
    $error("efx_fifo_5k: WIDTH must be one of 1,2,4,5,8,10,16,20");
  end

  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic                  w_ram_we;
  logic                  w_ram_re;

  efx_fifo_ctrl #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .AFULL_THRESH  (AFULL_THRESH),
    .AEMPTY_THRESH (AEMPTY_THRESH)
  ) u_ctrl (
    .i_clk       (i_clk),
    .i_sr        (i_sr),
    .i_we        (i_we),
    .i_re        (i_re),
    .o_waddr     (w_waddr),
    .o_raddr     (w_raddr),
    .o_ram_we_c  (w_ram_we),
    .o_ram_re_c  (w_ram_re),
    .o_count     (o_count),
    .o_full      (o_full),
    .o_afull     (o_afull),
    .o_empty     (o_empty),
    .o_aempty    (o_aempty),
    .o_rvalid    (o_rvalid),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  EFX_RAM_5K #(
    .READ_WIDTH     (WIDTH),
    .WRITE_WIDTH    (WIDTH),
    .OUTPUT_REG     (1'b0),
    .RCLK_POLARITY  (1'b1),
    .RE_POLARITY    (1'b1),
    .WCLK_POLARITY  (1'b1),
    .WCLKE_POLARITY (1'b1),
    .WE_POLARITY    (1'b1),
    .WRITE_MODE     ("READ_FIRST")
  ) u_ram (
    .WDATA (i_wdata),
    .WADDR (w_waddr),
    .WE    (w_ram_we),
    .WCLK  (i_clk),
    .WCLKE (1'b1),
    .RDATA (o_rdata),
    .RADDR (w_raddr),
    .RE    (w_ram_re),
    .RCLK  (i_clk)
  );

endmodule

// File: tb/tb_efx_fifo_5k.sv
// Testbench for efx_fifo_5k (WIDTH=10, DEPTH=512, AFULL=508, AEMPTY=4).
module tb_efx_fifo_5k;

  localparam int DEPTH = 512;
  localparam int AF    = 508;
  localparam int AE    = 4;

  logic       clk = 1'b0;
  logic       i_sr;
  logic       i_we;
  logic       i_re;
  logic [9:0] i_wdata;
  logic       o_full;
  logic       o_afull;
  logic [9:0] o_rdata;
  logic       o_rvalid;
  logic       o_empty;
  logic       o_aempty;
  logic [9:0] o_count;
  logic       o_overflow;
  logic       o_underflow;

  always #5 clk = ~clk;

  efx_fifo_5k dut (
    .i_clk       (clk),
    .i_sr        (i_sr),
    .i_wdata     (i_wdata),
    .i_we        (i_we),
    .o_full      (o_full),
    .o_afull     (o_afull),
    .i_re        (i_re),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .o_empty     (o_empty),
    .o_aempty    (o_aempty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  // Reference model state.
  int         m_cnt = 0;
  bit         m_rv  = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  logic [9:0] m_exp = '0;
  logic [9:0] q[$];

  typedef struct {
    logic       sr;
    logic       we;
    logic       re;
    logic [9:0] wd;
    int         cnt;
    logic       rv;
    logic [9:0] rd;
    logic       udf;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic sr, input logic we, input logic re,
                              input logic [9:0] wd, input int cnt, input logic rv,
                              input logic [9:0] rd, input logic udf);
    vec_t v;
    v.sr = sr; v.we = we; v.re = re; v.wd = wd;
    v.cnt = cnt; v.rv = rv; v.rd = rd; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cycle(input logic sr, input logic we, input logic re, input logic [9:0] wd);
    bit wacc;
    bit racc;
    i_sr    = sr;
    i_we    = we;
    i_re    = re;
    i_wdata = wd;
    wacc = we && !sr && (m_cnt != DEPTH);
    racc = re && !sr && (m_cnt != 0);
    @(posedge clk);
    cyc++;
    if (sr) begin
      m_cnt = 0;
      m_rv  = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      q.delete();
    end else begin
      m_ovf = we && (m_cnt == DEPTH);
      m_udf = re && (m_cnt == 0);
      m_rv  = racc;
      if (racc) m_exp = q.pop_front();
      if (wacc) q.push_back(wd);
      m_cnt = m_cnt + int'(wacc) - int'(racc);
    end
    @(negedge clk);
    chk("count",     32'(o_count),     32'(m_cnt));
    chk("empty",     32'(o_empty),     32'(m_cnt == 0));
    chk("full",      32'(o_full),      32'(m_cnt == DEPTH));
    chk("afull",     32'(o_afull),     32'(m_cnt >= AF));
    chk("aempty",    32'(o_aempty),    32'(m_cnt <= AE));
    chk("rvalid",    32'(o_rvalid),    32'(m_rv));
    chk("overflow",  32'(o_overflow),  32'(m_ovf));
    chk("underflow", 32'(o_underflow), 32'(m_udf));
    if (m_rv) chk("rdata", 32'(o_rdata), 32'(m_exp));
  endtask

  initial begin
    i_sr    = 1'b1;
    i_we    = 1'b0;
    i_re    = 1'b0;
    i_wdata = '0;

    // Basic write/read, underflow and empty WE+RE corners.
    tbl[0]  = mk(1, 0, 0, 10'h000, 0, 0, 10'h000, 0);
    tbl[1]  = mk(0, 1, 0, 10'h001, 1, 0, 10'h000, 0);
    tbl[2]  = mk(0, 1, 0, 10'h002, 2, 0, 10'h000, 0);
    tbl[3]  = mk(0, 1, 0, 10'h003, 3, 0, 10'h000, 0);
    tbl[4]  = mk(0, 1, 0, 10'h004, 4, 0, 10'h000, 0);
    tbl[5]  = mk(0, 1, 0, 10'h005, 5, 0, 10'h000, 0);
    tbl[6]  = mk(0, 0, 1, 10'h000, 4, 1, 10'h001, 0);
    tbl[7]  = mk(0, 0, 1, 10'h000, 3, 1, 10'h002, 0);
    tbl[8]  = mk(0, 0, 1, 10'h000, 2, 1, 10'h003, 0);
    tbl[9]  = mk(0, 0, 1, 10'h000, 1, 1, 10'h004, 0);
    tbl[10] = mk(0, 0, 1, 10'h000, 0, 1, 10'h005, 0);
    tbl[11] = mk(0, 0, 0, 10'h000, 0, 0, 10'h000, 0);
    tbl[12] = mk(0, 0, 1, 10'h000, 0, 0, 10'h000, 1);
    tbl[13] = mk(0, 1, 1, 10'h2AA, 1, 0, 10'h000, 1);
    tbl[14] = mk(0, 0, 1, 10'h000, 0, 1, 10'h2AA, 0);
    tbl[15] = mk(0, 0, 0, 10'h000, 0, 0, 10'h000, 0);

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].sr, tbl[i].we, tbl[i].re, tbl[i].wd);
      chk("tbl_count",     32'(o_count),     32'(tbl[i].cnt));
      chk("tbl_rvalid",    32'(o_rvalid),    32'(tbl[i].rv));
      chk("tbl_underflow", 32'(o_underflow), 32'(tbl[i].udf));
      if (tbl[i].rv) chk("tbl_rdata", 32'(o_rdata), 32'(tbl[i].rd));
    end

    // Fill to DEPTH; AFULL crossing at 508 checked by the model each cycle.
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 10'($urandom));
    chk("full_after_fill",  32'(o_full),  32'(1));
    chk("count_after_fill", 32'(o_count), 32'(512));

    // 513th write is rejected.
    cycle(0, 1, 0, 10'h3FF);
    chk("ovf_513th",       32'(o_overflow), 32'(1));
    chk("count_stays_512", 32'(o_count),    32'(512));

    // Full with WE+RE: read wins, write rejected.
    cycle(0, 1, 1, 10'h155);
    chk("full_wr_rd_rvalid", 32'(o_rvalid),   32'(1));
    chk("full_wr_rd_ovf",    32'(o_overflow), 32'(1));
    chk("full_wr_rd_count",  32'(o_count),    32'(511));
    chk("full_wr_rd_full",   32'(o_full),     32'(0));

    // Drain to 3; AEMPTY crossing at 4 checked by the model.
    for (int i = 0; i < 508; i++) cycle(0, 0, 1, 10'h000);
    chk("count_at_3", 32'(o_count), 32'(3));

    // Streaming through several pointer wraps.
    for (int i = 0; i < 2000; i++) cycle(0, 1, 1, 10'($urandom));
    chk("stream_count_3", 32'(o_count), 32'(3));

    // Read accepted, then reset the next cycle (with requests held high).
    cycle(0, 0, 1, 10'h000);
    chk("rvalid_before_sr", 32'(o_rvalid), 32'(1));
    cycle(1, 1, 1, 10'h0F0);
    chk("sr_rvalid", 32'(o_rvalid), 32'(0));
    chk("sr_empty",  32'(o_empty),  32'(1));
    chk("sr_count",  32'(o_count),  32'(0));

    // Operation resumes after reset.
    cycle(0, 1, 0, 10'h2C3);
    cycle(0, 0, 1, 10'h000);
    chk("post_sr_rdata", 32'(o_rdata), 32'(10'h2C3));
    cycle(0, 0, 0, 10'h000);
    chk("rdata_hold", 32'(o_rdata), 32'(10'h2C3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
